uart_recv: RTL and testbench
============================

Name: uart_recv

Overview:
- 8N1 UART receiver: LSB first, one start bit (0), eight data bits, one stop bit (1), line idle high.
- Bit period is CLKS_PER_BIT clocks, matching the core's transmitter timing.
- Deserialises rxd into a one-entry holding register with valid/read handshake, framing-error and overrun reporting.
- Sits between the external RX pin and the core's I/O load path.

Parameters:
- CLKS_PER_BIT, 4, clocks per UART bit. Must be even and at least 4. HALF = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- rxd  input  1  asynchronous serial input, idle high
- rd_en  input  1  consumer read strobe; pops holding register
- data  output  8  received byte; stable while valid=1
- valid  output  1  holding register full
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  sticky: byte dropped because register full
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Both synchroniser flops are set to 1, the FSM goes to IDLE, and bit/clock counters are cleared.
  - Reset overrides all other inputs, including mid-frame; any partial byte is discarded.
- Synchroniser: two flops on rxd. The FSM sees only the synchronised signal rx_s, which lags rxd by 2 clocks.
- Timing reference: t0 = first edge at which the first synchroniser flop captures rxd=0 while the FSM is in IDLE.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START and clear the clock counter (edge t0+2).
  - START: at edge t0+2+HALF (mid start bit), check rx_s.
    - rx_s=0: go to DATA with bit index 0.
    - rx_s=1: false start; return to IDLE with no outputs changed.
  - DATA: sample rx_s every CLKS_PER_BIT clocks.
    - Bit i (0..7) is captured at edge t0+2+HALF+(i+1)*CLKS_PER_BIT into shift position i (LSB first).
    - After bit 7, go to STOP.
  - STOP: sample at edge t0+2+HALF+9*CLKS_PER_BIT.
    - rx_s=1: byte complete; attempt to load the holding register, then go to IDLE.
    - rx_s=0: frame_err=1 for exactly one cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from being read as back-to-back start bits.
- busy=1 in every state except IDLE.
- Load rules at the stop-sample edge:
  - valid=0: data<=byte, valid<=1.
  - valid=1 and rd_en=1 on the same edge: data<=new byte, valid stays 1, overrun unchanged.
  - valid=1 and rd_en=0: new byte dropped, data keeps the old byte, overrun<=1.
- Latency, CLKS_PER_BIT=4: valid is high after edge t0+40. Return to IDLE is on the same edge, so a back-to-back start bit is accepted.
- Read and overrun:
  - rd_en with valid=1: valid<=0 on the next edge, and overrun is cleared on that edge.
  - rd_en with valid=0: ignored.
- Counters: clock counter width is clog2(CLKS_PER_BIT), wrapping at CLKS_PER_BIT-1. Bit index is 3 bits. No other wrap conditions exist.

Test Plan:
- Byte 0x55, CLKS_PER_BIT=4, clean framing, rd_en held 0 -> valid=1 after edge t0+40, data=0x55, frame_err never 1, busy=0 after that edge.
- Back-to-back 0xA3 then 0x0F, consumer pulsing rd_en as each valid appears -> data 0xA3 then 0x0F, overrun=0 throughout.
- Glitch: rxd low for 1 clock, then high -> busy rises briefly, FSM back in IDLE by t0+2+HALF+1, valid=0, no frame_err.
- Stop bit forced 0 on byte 0x81 -> single-cycle frame_err pulse at t0+40, valid stays 0. rxd then held low 20 clocks before returning high: FSM stays in WAIT_HIGH throughout, then receives 0x3C correctly.
- Overrun: send 0x11, do not read, send 0x22 -> data stays 0x11 and overrun=1. rd_en once -> valid=0, overrun=0.
- Reset asserted mid-frame at t0+20, then released -> all outputs 0, FSM in IDLE. The remaining line bits produce no spurious valid, and the next full frame of 0xC5 is received correctly.

Source files
------------

// File: rtl/uart_recv_if.sv
// ----------------------------------------------------------------------------
// uart_recv_if
//   Consumer-side handshake bundle of the UART receiver.
//
//   Signals:
//     rd_en     consumer read strobe; pops the holding register
//     data      received byte; stable while valid=1
//     valid     holding register full
//     frame_err one-cycle pulse: stop bit sampled low
//     overrun   sticky: a byte was dropped because the register was full
//     busy      receiver is somewhere inside a frame
//
//   Modports:
//     master  the receiver (drives the byte and status, reads rd_en)
//     slave   the consumer (reads the byte and status, drives rd_en)
// ----------------------------------------------------------------------------
interface uart_recv_if;
    logic       rd_en;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  rd_en,
        output data,
        output valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rd_en,
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_recv.sv
// ----------------------------------------------------------------------------
// uart_recv
//   8N1 UART receiver (LSB first, start bit 0, stop bit 1, idle high).
//   The asynchronous rxd pin is brought in through a two-flop synchroniser;
//   the frame FSM samples the synchronised line in the middle of every bit
//   and delivers each good byte into a one-entry holding register with a
//   valid/read handshake. Stop-bit errors and dropped bytes are reported.
//
//   Ports:
//     clk    system clock, all logic on posedge
//     rst    synchronous, active-high reset
//     rxd    asynchronous serial input, idle high
//     rx_if  consumer handshake (uart_recv_if.master):
//            rd_en in; data, valid, frame_err, overrun, busy out
//
//   Parameters:
//     CLKS_PER_BIT  clocks per UART bit; even and at least 4
// ----------------------------------------------------------------------------
module uart_recv #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rxd,
    uart_recv_if.master  rx_if
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          sync1;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic [7:0]    data_q;
    logic          valid_q;
    logic          frame_err_q;
    logic          overrun_q;

    // FSM decode strobes
    logic          cnt_clr;
    logic          shift_en;
    logic          load_req;
    logic          frame_bad;

    // ------------------------------------------------------------------------
    // Synchroniser. Resets to the idle level so a reset never looks like a
    // start bit.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: every clocked process uses non-blocking assignments so all
        // registers update together from pre-edge values, independent of
        // evaluation order between processes.
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rxd;
            rx_s  <= sync1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and decode strobes
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        load_req  = 1'b0;
        frame_bad = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt = S_START;
                    cnt_clr   = 1'b1;
                end
            end

            // Half a bit in: the line must still be low, otherwise it was a
            // glitch and we silently go back to waiting.
            S_START: begin
                if (clk_cnt == HALF_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end

            // Counter wraps at CNT_LAST, so each sample lands one full bit
            // after the previous one, i.e. mid-bit.
            S_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    if (rx_s) begin
                        load_req  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = S_WAIT_HIGH;
                    end
                end
            end

            // A held-low line (break) must not be taken as a run of start bits.
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bit-timing counter, bit index and shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (cnt_clr || state == S_IDLE || clk_cnt == CNT_LAST) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            if (cnt_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end

            // LSB arrives first, so shifting in at the top leaves bit 0 at
            // position 0 after the eighth sample.
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Holding register, handshake and status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;

            if (load_req) begin
                // A same-edge read frees the slot, so the new byte replaces
                // the old one and nothing is counted as lost.
                if (!valid_q || rx_if.rd_en) begin
                    data_q  <= shreg;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_if.rd_en && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx_if.data      = data_q;
    assign rx_if.valid     = valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
    assign rx_if.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// ----------------------------------------------------------------------------
// tb_uart_recv
//   Self-checking bench for uart_recv with CLKS_PER_BIT=4. Frames are driven
//   on rxd one clock at a time; outputs are sampled 1 time unit after each
//   rising edge. A directed table, hand-written corner sequences and a
//   randomised run checked against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_uart_recv;

    localparam int CPB       = 4;
    localparam int FRAME_LEN = 10 * CPB + 1;   // ticks per send_frame call

    logic clk = 1'b0;
    logic rst;
    logic rxd;

    always #5 clk = ~clk;

    uart_recv_if u_if ();

    uart_recv #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rx_if (u_if.master)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic v_at_40;

    // Transaction-level model of the holding register
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovr;

    typedef struct {
        logic [7:0] din;
        logic       stop_ok;
        int         read_at;   // tick index of a one-cycle rd_en, 0 = none
        int         gap;       // idle ticks before the frame
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_ovr;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives one full frame. Tick k reaches edge E0+k, where E0 is the edge
    // just before the call; the start bit is first captured at E0+1 (t0), so
    // the stop-sample edge t0+40 is tick 41. rd_en is high on tick read_at.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                              input int read_at, input logic end_lvl);
        logic [10:0] lv;
        lv = {end_lvl, stop_lvl, b, 1'b0};
        for (int k = 1; k <= FRAME_LEN; k++) begin
            rxd        = lv[(k - 1) / CPB];
            u_if.rd_en = (k == read_at);
            tick();
            if (k == FRAME_LEN - 1) v_at_40 = u_if.valid;
        end
        u_if.rd_en = 1'b0;
    endtask

    task automatic read_pulse();
        u_if.rd_en = 1'b1;
        tick();
        u_if.rd_en = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [7:0] d,
                             input logic fe, input logic ov, input logic bz);
        check({tag, " valid"},     u_if.valid,     v);
        check({tag, " data"},      u_if.data,      d);
        check({tag, " frame_err"}, u_if.frame_err, fe);
        check({tag, " overrun"},   u_if.overrun,   ov);
        check({tag, " busy"},      u_if.busy,      bz);
    endtask

    initial begin
        logic [10:0] lv;

        //                din    ok  rd  gap  v  data   fe ov busy
        tbl[0]  = '{8'h55, 1'b1,  0,  2, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{8'hA3, 1'b1,  2,  3, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'h0F, 1'b1,  2,  0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'h11, 1'b1,  2,  3, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'h22, 1'b1,  0,  3, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{8'h81, 1'b0,  2,  3, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{8'h3C, 1'b1,  0,  4, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{8'hC5, 1'b1, 41,  3, 1'b1, 8'hC5, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h00, 1'b1,  0,  3, 1'b1, 8'hC5, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{8'hFF, 1'b1, 41,  3, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{8'h5A, 1'b1,  5,  3, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};

        rst        = 1'b1;
        rxd        = 1'b1;
        u_if.rd_en = 1'b0;
        repeat (3) tick();
        check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // ---------------- directed table ----------------
        foreach (tbl[i]) begin
            idle(tbl[i].gap);
            send_frame(tbl[i].din, tbl[i].stop_ok, tbl[i].read_at, 1'b1);
            if (i == 0) check("latency valid before t0+40", v_at_40, 1'b0);
            check_all($sformatf("tbl%0d", i), tbl[i].exp_valid, tbl[i].exp_data,
                      tbl[i].exp_ferr, tbl[i].exp_ovr, tbl[i].exp_busy);
            tick();
            check($sformatf("tbl%0d frame_err pulse end", i), u_if.frame_err, 1'b0);
        end

        // ---------------- break after bad stop ----------------
        read_pulse();
        check_all("pop", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle(2);
        send_frame(8'h81, 1'b0, 0, 1'b0);
        check_all("break stop", 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("break busy %0d", i), u_if.busy, 1'b1);
        end
        check("break frame_err", u_if.frame_err, 1'b0);
        check("break valid", u_if.valid, 1'b0);
        idle(4);
        check("break released busy", u_if.busy, 1'b0);
        send_frame(8'h3C, 1'b1, 0, 1'b1);
        check_all("after break", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        read_pulse();

        // ---------------- one-clock glitch ----------------
        idle(3);
        rxd = 1'b0;
        tick();                      // t0
        rxd = 1'b1;
        tick();                      // t0+1
        check("glitch busy t0+1", u_if.busy, 1'b0);
        tick();                      // t0+2
        check("glitch busy t0+2", u_if.busy, 1'b1);
        tick();
        tick();                      // t0+2+HALF
        check("glitch busy t0+4", u_if.busy, 1'b0);
        idle(10);
        check_all("glitch end", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

        // ---------------- reset mid-frame ----------------
        send_frame(8'h77, 1'b1, 0, 1'b1);
        check_all("pre-reset", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        idle(3);
        lv = {1'b1, 1'b1, 8'hF2, 1'b0};   // bits still to come after reset are all 1
        for (int k = 1; k <= FRAME_LEN; k++) begin
            rxd = lv[(k - 1) / CPB];
            rst = (k == 21);              // edge t0+20
            tick();
            if (k == 21) check_all("mid reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        idle(50);
        check_all("post reset idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC5, 1'b1, 0, 1'b1);
        check_all("post reset frame", 1'b1, 8'hC5, 1'b0, 1'b0, 1'b0);

        // ---------------- randomised against the model ----------------
        m_valid = 1'b1;
        m_data  = 8'hC5;
        m_ovr   = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            logic       ok;
            int         rd_at;
            b     = 8'($urandom);
            ok    = ($urandom_range(0, 7) != 0);
            rd_at = $urandom_range(0, 48);

            idle($urandom_range(3, 8));
            send_frame(b, ok, rd_at, 1'b1);

            if (rd_at >= 1 && rd_at < FRAME_LEN && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            if (ok) begin
                if (!m_valid) begin
                    m_data  = b;
                    m_valid = 1'b1;
                end else if (rd_at == FRAME_LEN) begin
                    m_data = b;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (rd_at == FRAME_LEN && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end

            check_all($sformatf("rnd%0d", n), m_valid, m_data, !ok, m_ovr, !ok);
            tick();
            check($sformatf("rnd%0d frame_err pulse end", n), u_if.frame_err, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
